// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register IDs for rename: multi-lane compacted allocate,
// multi-lane free, and a committed head so a flush rolls back speculative allocations in one cycle.
module phys_reg_freelist #(
   parameter int PHY_REGS  = 64,
   parameter int ARCH_REGS = 32,
   parameter int ALLOC_W   = 2,
   parameter int FREE_W    = 2,
   parameter int PHY_WIDTH = $clog2(PHY_REGS),
   parameter int DEPTH     = PHY_REGS - ARCH_REGS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ALLOC_W-1:0]             alloc_req,
   output logic                           alloc_gnt,
   output logic [ALLOC_W*PHY_WIDTH-1:0]   alloc_preg,
   input  logic [FREE_W-1:0]              retire_valid,
   input  logic [FREE_W-1:0]              free_valid,
   input  logic [FREE_W*PHY_WIDTH-1:0]    free_preg,
   input  logic                           flush,
   output logic [$clog2(DEPTH):0]         free_count,
   output logic                           overflow_err
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

   logic [PHY_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     spec_head, commit_head, tail;

   logic [PTR_W-1:0] n_req, k, lane_ptr;
   logic [PTR_W-1:0] n_ret, commit_nxt;
   logic             ret_ovf;
   logic [PTR_W-1:0] space, m, n_acc;
   logic             push_ovf;
   logic [PTR_W-1:0] wr_ptr [FREE_W];
   logic             wr_en  [FREE_W];

   assign free_count = tail - spec_head;

   // Lane i reads the slot offset by the number of requesting lanes below it.
   always_comb begin
      k          = '0;
      lane_ptr   = '0;
      alloc_preg = '0;
      for (int i = 0; i < ALLOC_W; i++) begin
         lane_ptr = spec_head + k;
         alloc_preg[i*PHY_WIDTH +: PHY_WIDTH] = mem[lane_ptr[IDX_W-1:0]];
         k = k + PTR_W'(alloc_req[i]);
      end
      n_req = k;
   end

   assign alloc_gnt = !flush && (n_req <= free_count);

   always_comb begin
      n_ret = '0;
      for (int i = 0; i < FREE_W; i++) n_ret = n_ret + PTR_W'(retire_valid[i]);
   end

   // Retiring more than was speculatively allocated is a protocol error; clamp.
   assign ret_ovf    = n_ret > (spec_head - commit_head);
   assign commit_nxt = ret_ovf ? spec_head : commit_head + n_ret;

   // Room is measured against the committed head: slots between commit and spec head are still live.
   assign space = DEPTH_P - (tail - commit_head);

   always_comb begin
      m        = '0;
      push_ovf = 1'b0;
      for (int i = 0; i < FREE_W; i++) begin
         wr_ptr[i] = tail + m;
         wr_en[i]  = 1'b0;
         if (free_valid[i]) begin
            if (m < space) begin
               wr_en[i] = 1'b1;
               m        = m + 1'b1;
            end else begin
               push_ovf = 1'b1;
            end
         end
      end
      n_acc = m;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= PHY_WIDTH'(ARCH_REGS + i);
         spec_head    <= '0;
         commit_head  <= '0;
         tail         <= DEPTH_P;
         overflow_err <= 1'b0;
      end else begin
         for (int i = 0; i < FREE_W; i++)
            if (wr_en[i]) mem[wr_ptr[i][IDX_W-1:0]] <= free_preg[i*PHY_WIDTH +: PHY_WIDTH];
         tail        <= tail + n_acc;
         commit_head <= commit_nxt;
         if (flush)
            spec_head <= commit_nxt;
         else if (alloc_gnt)
            spec_head <= spec_head + n_req;
         if (ret_ovf || push_ovf) overflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_phys_reg_freelist.sv
// Bench for phys_reg_freelist: queue-based free-list model checked every cycle, plus directed literal checks.
module tb_phys_reg_freelist;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  alloc_req;
   logic        alloc_gnt;
   logic [11:0] alloc_preg;
   logic [1:0]  retire_valid;
   logic [1:0]  free_valid;
   logic [11:0] free_preg;
   logic        flush;
   logic [5:0]  free_count;
   logic        overflow_err;

   phys_reg_freelist dut (
      .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
      .alloc_preg(alloc_preg), .retire_valid(retire_valid), .free_valid(free_valid),
      .free_preg(free_preg), .flush(flush), .free_count(free_count),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: fl holds IDs from the committed head to the tail; the first spec_off are speculatively allocated.
   int fl[$];
   int retired_q[$];
   int spec_off;
   bit m_err;
   bit inuse[64];

   function automatic int m_fc();
      return fl.size() - spec_off;
   endfunction

   function automatic int preg(int l);
      return int'(alloc_preg[l*6 +: 6]);
   endfunction

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      int nreq, nret, nfree, space, id;
      bit gnt;
      if (rst) begin
         fl.delete();
         retired_q.delete();
         for (int i = 0; i < 32; i++) fl.push_back(32 + i);
         for (int i = 0; i < 64; i++) inuse[i] = (i < 32);
         spec_off = 0;
         m_err    = 1'b0;
      end else begin
         nreq  = $countones(alloc_req);
         gnt   = !flush && (nreq <= m_fc());
         space = 32 - fl.size();
         if (gnt)
            for (int j = 0; j < nreq; j++) inuse[fl[spec_off + j]] = 1'b1;
         nret = $countones(retire_valid);
         if (nret > spec_off) begin
            m_err = 1'b1;
            nret  = spec_off;
         end
         for (int j = 0; j < nret; j++) retired_q.push_back(fl.pop_front());
         spec_off = spec_off - nret + (gnt ? nreq : 0);
         if (flush) begin
            for (int j = 0; j < spec_off; j++) inuse[fl[j]] = 1'b0;
            spec_off = 0;
         end
         nfree = 0;
         for (int l = 0; l < 2; l++) begin
            if (free_valid[l]) begin
               if (nfree < space) begin
                  id = int'(free_preg[l*6 +: 6]);
                  fl.push_back(id);
                  inuse[id] = 1'b0;
                  if (retired_q.size() > 0 && retired_q[0] == id) void'(retired_q.pop_front());
                  nfree++;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      int nreq, k, id;
      bit exp_gnt;
      if (chk_en) begin
         nreq    = $countones(alloc_req);
         exp_gnt = !flush && (nreq <= m_fc());
         chk("gnt", int'(alloc_gnt), int'(exp_gnt));
         chk("free_count", int'(free_count), m_fc());
         chk("overflow_err", int'(overflow_err), int'(m_err));
         if (exp_gnt) begin
            k = 0;
            for (int l = 0; l < 2; l++) begin
               if (alloc_req[l]) begin
                  id = preg(l);
                  chk($sformatf("preg_lane%0d", l), id, fl[spec_off + k]);
                  chk($sformatf("dup_lane%0d", l), int'(inuse[id]), 0);
                  k++;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_req = '0; retire_valid = '0; free_valid = '0; free_preg = '0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
   endtask

   // Retire/free stimulus derived from the model's outstanding allocations.
   task automatic drive_ret_free(int want_r, int want_f, int sel);
      int nr, nf;
      nr = (want_r > spec_off) ? spec_off : want_r;
      retire_valid = (nr == 2) ? 2'b11 : (nr == 1) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      nf = (want_f > retired_q.size()) ? retired_q.size() : want_f;
      if (nf == 2) begin
         free_valid = 2'b11;
         free_preg[5:0]  = 6'(retired_q[0]);
         free_preg[11:6] = 6'(retired_q[1]);
      end else if (nf == 1) begin
         free_valid[sel] = 1'b1;
         free_preg[sel*6 +: 6] = 6'(retired_q[0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      cyc();
      do_reset();
      chk_en = 1'b1;

      // 1: two-lane allocate straight out of reset
      chk("t1_fc_reset", int'(free_count), 32);
      chk("t1_err_reset", int'(overflow_err), 0);
      alloc_req = 2'b11; #2;
      chk("t1_gnt", int'(alloc_gnt), 1);
      chk("t1_p0", preg(0), 32);
      chk("t1_p1", preg(1), 33);
      cyc(); #2;
      chk("t1_fc", int'(free_count), 30);
      chk("t1_p0b", preg(0), 34);
      chk("t1_p1b", preg(1), 35);

      // 2: lane compaction
      do_reset();
      alloc_req = 2'b10; #2;
      chk("t2_p1", preg(1), 32);
      cyc();
      alloc_req = 2'b11; #2;
      chk("t2_p0", preg(0), 33);
      chk("t2_p1b", preg(1), 34);

      // 3: drain to empty, all-or-none grant
      do_reset();
      alloc_req = 2'b11;
      repeat (15) cyc();
      alloc_req = 2'b01;
      cyc();
      alloc_req = 2'b11; #2;
      chk("t3_gnt_none", int'(alloc_gnt), 0);
      chk("t3_fc1", int'(free_count), 1);
      cyc();
      alloc_req = 2'b01; #2;
      chk("t3_gnt_last", int'(alloc_gnt), 1);
      chk("t3_p63", preg(0), 63);
      cyc();
      alloc_req = 2'b00; #2;
      chk("t3_fc0", int'(free_count), 0);
      chk("t3_gnt_zero_req", int'(alloc_gnt), 1);

      // 4: flush with a same-cycle retire
      do_reset();
      alloc_req = 2'b11;
      repeat (3) cyc();
      idle();
      flush = 1'b1; retire_valid = 2'b01; #2;
      chk("t4_gnt_flush", int'(alloc_gnt), 0);
      cyc();
      idle();
      alloc_req = 2'b01; #2;
      chk("t4_fc", int'(free_count), 31);
      chk("t4_p0", preg(0), 33);

      // 5: long mixed run wrapping the queue several times
      do_reset();
      for (int i = 0; i < 100; i++) begin
         idle();
         case (i % 4)
            0: alloc_req = 2'b11;
            1: alloc_req = 2'b01;
            2: alloc_req = 2'b10;
            default: alloc_req = 2'b11;
         endcase
         if (i % 7 == 6) alloc_req = 2'b00;
         drive_ret_free((i % 3 == 0) ? 2 : 1, (i % 3 == 2) ? 2 : 1, i % 2);
         if (i == 40) flush = 1'b1;
         cyc();
      end
      for (int i = 0; i < 200; i++) begin
         if (spec_off == 0 && retired_q.size() == 0) break;
         idle();
         drive_ret_free(2, 2, 0);
         cyc();
      end
      idle(); #2;
      chk("t5_drained", spec_off + retired_q.size(), 0);
      chk("t5_fc_full", int'(free_count), 32);
      chk("t5_err", int'(overflow_err), 0);

      // 6: push while full is sticky until reset
      do_reset();
      free_valid = 2'b11; free_preg = {6'd5, 6'd4};
      cyc();
      idle(); #2;
      chk("t6_err_set", int'(overflow_err), 1);
      chk("t6_fc_full", int'(free_count), 32);
      cyc(); #2;
      chk("t6_err_sticky", int'(overflow_err), 1);
      alloc_req = 2'b11;
      cyc();
      do_reset(); #2;
      chk("t6_err_clr", int'(overflow_err), 0);
      chk("t6_fc_rst", int'(free_count), 32);
      cyc();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
